// File: rtl/iic_pkg.sv
// Shared state encoding and board constants for the I2C register-file target.
package iic_pkg;

    localparam logic [6:0] MS7200_DEV_ADDR = 7'h2B;
    localparam logic [6:0] MS7210_DEV_ADDR = 7'h59;
    localparam logic [6:0] DEF_DEV_ADDR    = MS7200_DEV_ADDR;

    localparam int unsigned ADDR_BYTES = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV,
        S_DEV_ACK,
        S_AH,
        S_AH_ACK,
        S_AL,
        S_AL_ACK,
        S_WDAT,
        S_WDAT_ACK,
        S_RDAT,
        S_RDAT_ACK
    } iic_state_t;

endpackage

// File: rtl/iic_line_filter.sv
// SCL/SDA synchronizer, glitch filter and bus-event detection.
module iic_line_filter #(
    parameter int unsigned FILT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    localparam int CW = $clog2(FILT + 1);
    localparam logic [CW-1:0] CMAX = CW'(FILT - 1);

    // Bit 0 is SCL, bit 1 is SDA; an idle bus reads high on both.
    logic [1:0]    in_w;
    logic [1:0]    s1_q;
    logic [1:0]    s2_q;
    logic [1:0]    f_q;
    logic [1:0]    p_q;
    logic [CW-1:0] cnt_q [2];

    assign in_w = {sda_i, scl_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '1;
            s2_q <= '1;
            f_q  <= '1;
            p_q  <= '1;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            s1_q <= in_w;
            s2_q <= s1_q;
            p_q  <= f_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == f_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CMAX) begin
                    f_q[i]   <= s2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign sda_o      = f_q[1];
    assign scl_rise_o = f_q[0] & ~p_q[0];
    assign scl_fall_o = ~f_q[0] & p_q[0];
    assign start_o    = p_q[0] & p_q[1] & ~f_q[1];
    assign stop_o     = p_q[0] & ~p_q[1] & f_q[1];

endmodule

// File: rtl/iic_slave_regif.sv
// I2C target with 16-bit register pointer and 8-bit data, bridged to a
// single-cycle register-file strobe port.
module iic_slave_regif
    import iic_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
    parameter int unsigned FILT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iic_scl,
    input  logic        sda_in,
    output logic        sda_out_en,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    iic_line_filter #(
        .FILT(FILT)
    ) u_filt (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (iic_scl),
        .sda_i     (sda_in),
        .sda_o     (sda_f),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start),
        .stop_o    (stop)
    );

    iic_state_t  state_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic [7:0]  wdata_q;
    logic [15:0] ptr_q;
    logic        oe_q;
    logic        we_q;
    logic        re_q;
    logic        load_q;
    logic        busy_q;
    logic        rw_q;
    logic        ack_q;
    logic [7:0]  byte_d;
    logic        last_d;

    assign byte_d = {shift_q[6:0], sda_f};
    assign last_d = (bit_q == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            load_q <= re_q;
            if (we_q) ptr_q <= ptr_q + 16'd1;
            // Read data arrives one cycle after the strobe; MSB goes out at once.
            if (load_q && state_q == S_RDAT) begin
                shift_q <= reg_rdata;
                oe_q    <= ~reg_rdata[7];
                ptr_q   <= ptr_q + 16'd1;
            end
            if (start) begin
                state_q <= S_DEV;
                bit_q   <= '0;
                oe_q    <= 1'b0;
                ack_q   <= 1'b0;
            end else if (stop) begin
                state_q <= S_IDLE;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
                ack_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                    end
                    S_DEV, S_AH, S_AL, S_WDAT: begin
                        if (scl_rise) begin
                            shift_q <= byte_d;
                            bit_q   <= bit_q + 3'd1;
                            if (last_d) begin
                                unique case (state_q)
                                    S_DEV: begin
                                        if (byte_d[7:1] == DEV_ADDR) begin
                                            state_q <= S_DEV_ACK;
                                            rw_q    <= byte_d[0];
                                            busy_q  <= 1'b1;
                                        end else begin
                                            state_q <= S_IDLE;
                                            oe_q    <= 1'b0;
                                            busy_q  <= 1'b0;
                                        end
                                    end
                                    S_AH: begin
                                        ptr_q[15:8] <= byte_d;
                                        state_q     <= S_AH_ACK;
                                    end
                                    S_AL: begin
                                        ptr_q[7:0] <= byte_d;
                                        state_q    <= S_AL_ACK;
                                    end
                                    default: begin
                                        wdata_q <= byte_d;
                                        we_q    <= 1'b1;
                                        state_q <= S_WDAT_ACK;
                                    end
                                endcase
                            end
                        end
                    end
                    S_DEV_ACK, S_AH_ACK, S_AL_ACK, S_WDAT_ACK: begin
                        // First fall opens the ACK slot, second fall closes it.
                        if (scl_fall) begin
                            if (!ack_q) begin
                                oe_q  <= 1'b1;
                                ack_q <= 1'b1;
                            end else begin
                                oe_q  <= 1'b0;
                                ack_q <= 1'b0;
                                bit_q <= '0;
                                unique case (state_q)
                                    S_DEV_ACK: begin
                                        if (rw_q) begin
                                            state_q <= S_RDAT;
                                            re_q    <= 1'b1;
                                        end else begin
                                            state_q <= S_AH;
                                        end
                                    end
                                    S_AH_ACK: state_q <= S_AL;
                                    default:  state_q <= S_WDAT;
                                endcase
                            end
                        end
                    end
                    S_RDAT: begin
                        if (scl_rise) bit_q <= bit_q + 3'd1;
                        if (scl_fall) begin
                            if (bit_q == 3'd0) begin
                                oe_q    <= 1'b0;
                                state_q <= S_RDAT_ACK;
                            end else begin
                                shift_q <= {shift_q[6:0], 1'b0};
                                oe_q    <= ~shift_q[6];
                            end
                        end
                    end
                    S_RDAT_ACK: begin
                        if (scl_rise && sda_f) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else if (scl_fall) begin
                            state_q <= S_RDAT;
                            bit_q   <= '0;
                            re_q    <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sda_out_en = oe_q;
    assign reg_addr   = ptr_q;
    assign reg_wdata  = wdata_q;
    assign reg_we     = we_q;
    assign reg_re     = re_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_iic_slave_regif.sv
// Bit-banged I2C master plus register-bank model driving iic_slave_regif.
module tb_iic_slave_regif;
    import iic_pkg::*;

    localparam int Q    = 10;
    localparam int FILT = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        bus_sda;
    logic        sda_out_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_rdata;
    logic        busy;

    assign bus_sda = sda_m & ~sda_out_en;

    always #5 clk = ~clk;

    iic_slave_regif #(
        .DEV_ADDR(7'h2B),
        .FILT    (FILT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iic_scl   (scl_m),
        .sda_in    (bus_sda),
        .sda_out_en(sda_out_en),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    logic [7:0]  bank [0:65535];
    logic [15:0] we_a [0:63];
    logic [7:0]  we_d [0:63];
    int we_n   = 0;
    int re_n   = 0;
    int oe_n   = 0;
    int busy_n = 0;
    int ovl_n  = 0;

    always @(posedge clk) begin
        if (reg_we) begin
            bank[reg_addr]  <= reg_wdata;
            we_a[we_n[5:0]] <= reg_addr;
            we_d[we_n[5:0]] <= reg_wdata;
            we_n            <= we_n + 1;
        end
        if (reg_re) begin
            reg_rdata <= bank[reg_addr];
            re_n      <= re_n + 1;
        end
        if (sda_out_en) oe_n <= oe_n + 1;
        if (busy) busy_n <= busy_n + 1;
        if (reg_we && reg_re) ovl_n <= ovl_n + 1;
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b, input logic glitch);
        sda_m = b;
        wq(Q);
        scl_m = 1'b1;
        wq(Q);
        if (glitch) begin
            scl_m = 1'b0;
            wq(FILT - 1);
            scl_m = 1'b1;
        end
        wq(Q);
        scl_m = 1'b0;
        wq(Q);
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1;
        wq(Q);
        scl_m = 1'b1;
        wq(Q);
        b = bus_sda;
        wq(Q);
        scl_m = 1'b0;
        wq(Q);
    endtask

    task automatic byte_out(input logic [7:0] d, input int gbit,
                            output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(d[i], i == gbit);
        bit_in(ack);
    endtask

    task automatic byte_in(output logic [7:0] d, input logic nack);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_in(b);
            d = {d[6:0], b};
        end
        bit_out(nack, 1'b0);
    endtask

    task automatic m_start;
        sda_m = 1'b1;
        wq(Q);
        scl_m = 1'b1;
        wq(Q);
        sda_m = 1'b0;
        wq(Q);
        scl_m = 1'b0;
        wq(Q);
    endtask

    task automatic m_stop;
        sda_m = 1'b0;
        wq(Q);
        scl_m = 1'b1;
        wq(Q);
        sda_m = 1'b1;
        wq(Q);
    endtask

    task automatic wr_hdr(input logic [7:0] dev, input logic [15:0] p,
                          output logic [2:0] acks);
        logic a;
        m_start;
        byte_out(dev, -1, a);
        acks[2] = a;
        byte_out(p[15:8], -1, a);
        acks[1] = a;
        byte_out(p[7:0], -1, a);
        acks[0] = a;
    endtask

    typedef struct {
        logic [7:0]  dev;
        logic [15:0] ptr;
        logic [7:0]  data;
        logic [3:0]  acks;
        logic        we;
        logic [15:0] ptr_after;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [2:0]  h;
        logic [3:0]  acks;
        logic        a;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [5:0]  ix;
        int          w0;
        int          r0;
        int          o0;
        int          b0;
        int          n;

        vecs[0] = '{8'h56, 16'h1234, 8'hA5, 4'b0000, 1'b1, 16'h1235};
        vecs[1] = '{8'h58, 16'h0000, 8'h77, 4'b1111, 1'b0, 16'h1235};
        vecs[2] = '{8'h56, 16'h0011, 8'hC3, 4'b0000, 1'b1, 16'h0012};
        vecs[3] = '{8'h56, 16'h0010, 8'h3C, 4'b0000, 1'b1, 16'h0011};
        vecs[4] = '{8'h54, 16'hABCD, 8'hFF, 4'b1111, 1'b0, 16'h0011};

        wq(5);
        chk("reset outputs",
            {4'h0, sda_out_en, reg_we, reg_re, busy, reg_wdata, reg_addr},
            32'h0);
        rst = 1'b0;
        wq(20);

        for (int i = 0; i < 5; i++) begin
            w0 = we_n;
            o0 = oe_n;
            b0 = busy_n;
            wr_hdr(vecs[i].dev, vecs[i].ptr, h);
            byte_out(vecs[i].data, -1, a);
            acks = {h, a};
            m_stop;
            wq(4);
            chk($sformatf("v%0d acks", i), 32'(acks), 32'(vecs[i].acks));
            chk($sformatf("v%0d we count", i), we_n - w0, 32'(vecs[i].we));
            chk($sformatf("v%0d sda driven", i), 32'(oe_n != o0),
                32'(vecs[i].we));
            chk($sformatf("v%0d busy seen", i), 32'(busy_n != b0),
                32'(vecs[i].we));
            chk($sformatf("v%0d busy after stop", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d pointer", i), 32'(reg_addr),
                32'(vecs[i].ptr_after));
            if (vecs[i].we) begin
                ix = w0[5:0];
                chk($sformatf("v%0d we addr", i), 32'(we_a[ix]),
                    32'(vecs[i].ptr));
                chk($sformatf("v%0d we data", i), 32'(we_d[ix]),
                    32'(vecs[i].data));
            end
        end

        // Combined read with repeated start.
        r0 = re_n;
        wr_hdr(8'h56, 16'h0010, h);
        m_start;
        byte_out(8'h57, -1, a);
        chk("rd acks", 32'({h, a}), 32'h0);
        byte_in(d0, 1'b0);
        byte_in(d1, 1'b1);
        m_stop;
        wq(4);
        chk("rd byte0", 32'(d0), 32'h3C);
        chk("rd byte1", 32'(d1), 32'hC3);
        chk("rd re count", re_n - r0, 32'd2);
        chk("rd pointer", 32'(reg_addr), 32'h0012);
        chk("rd busy", 32'(busy), 32'h0);

        // Pointer wrap-around.
        w0 = we_n;
        wr_hdr(8'h56, 16'hFFFF, h);
        byte_out(8'h01, -1, a);
        byte_out(8'h02, -1, a);
        m_stop;
        wq(4);
        chk("wrap we count", we_n - w0, 32'd2);
        ix = w0[5:0];
        chk("wrap addr0", 32'(we_a[ix]), 32'hFFFF);
        chk("wrap data0", 32'(we_d[ix]), 32'h01);
        ix = ix + 6'd1;
        chk("wrap addr1", 32'(we_a[ix]), 32'h0000);
        chk("wrap data1", 32'(we_d[ix]), 32'h02);
        chk("wrap pointer", 32'(reg_addr), 32'h0001);

        // Stop after five data bits.
        w0 = we_n;
        wr_hdr(8'h56, 16'h0020, h);
        for (int i = 0; i < 5; i++) bit_out(1'b1, 1'b0);
        m_stop;
        wq(4);
        chk("abort we count", we_n - w0, 32'd0);
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort pointer", 32'(reg_addr), 32'h0020);

        // SCL glitch inside a data bit.
        w0 = we_n;
        wr_hdr(8'h56, 16'h0030, h);
        byte_out(8'h5A, 4, a);
        m_stop;
        wq(4);
        chk("glitch acks", 32'({h, a}), 32'h0);
        chk("glitch we count", we_n - w0, 32'd1);
        ix = w0[5:0];
        chk("glitch addr", 32'(we_a[ix]), 32'h0030);
        chk("glitch data", 32'(we_d[ix]), 32'h5A);
        chk("glitch pointer", 32'(reg_addr), 32'h0031);

        // Reset while the target drives read data (0x5A, MSB 0).
        wr_hdr(8'h56, 16'h0030, h);
        m_start;
        byte_out(8'h57, -1, a);
        n = 0;
        while (!sda_out_en && n < 50) begin
            wq(1);
            n++;
        end
        chk("rst drive before", 32'(sda_out_en), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst sda released", 32'(sda_out_en), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst pointer", 32'(reg_addr), 32'h0000);
        wq(1);
        rst = 1'b0;
        wq(10);
        m_stop;
        wq(10);

        chk("strobe overlap", ovl_n, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/iic_slave_regif.md
# iic_slave_regif

I2C target (slave) that answers the same 16-bit-register-address, 8-bit-data transactions our `iic_dri` master issues to the MS72xx parts. It exposes a simple register-file port, so on-board controllers and test fixtures can present a register map on the HDMI card's configuration bus. The block sits between the board SCL/SDA pads and a local register bank. It oversamples both lines on the system clock.

## Interface
- `DEV_ADDR`, default 7'h2B: 7-bit target address (8-bit write form 8'h56).
- `FILT`, default 4: SCL/SDA glitch-filter length in clk cycles; a level must be stable for FILT cycles before it is accepted.
- `clk` in 1: system clock, ≥ 20× SCL rate (10 MHz for 400 kHz).
- `rst` in 1: synchronous, active-high reset.
- `iic_scl` in 1: bus clock (target never stretches).
- `sda_in` in 1: bus data as read from the pad.
- `sda_out_en` out 1: 1 = pull SDA low; the pad is `sda_out_en ? 0 : z`.
- `reg_addr` out 16: register pointer presented with `reg_we` and `reg_re`.
- `reg_wdata` out 8: write data, valid with `reg_we`.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid exactly one cycle after `reg_re`.
- `busy` out 1: high from the START that addressed this target until STOP, or until return to IDLE.

## Operation
- **Input conditioning.** 2-FF synchronizer per line, then the FILT-cycle filter.
  - The filtered lines produce `scl_rise`, `scl_fall`, `start` (SDA falls while SCL high) and `stop` (SDA rises while SCL high).
- **Bit timing.** Bits are sampled on `scl_rise`, MSB first. All SDA output changes happen on the cycle after `scl_fall`.
- **States.** IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK.
- **Start and stop.**
  - `start` from any state → DEV with the bit counter cleared. This covers repeated start.
  - `stop` from any state → IDLE, with `sda_out_en` = 0 and `busy` = 0.
- **Device byte (DEV).**
  - After 8 bits, if [7:1] == DEV_ADDR, go to DEV_ACK and drive ACK.
  - Otherwise release SDA and go to IDLE; the target ignores the bus until the next `start`.
- **R/W bit = 0 (write).** DEV_ACK → AH → AH_ACK → AL → AL_ACK, loading the pointer high byte then low byte. Then WDAT/WDAT_ACK repeats.
  - Each received data byte pulses `reg_we` on the cycle after its 8th `scl_rise`, with `reg_addr` = pointer and `reg_wdata` = byte.
  - The pointer increments on the following cycle. Every byte is ACKed.
- **R/W bit = 1 (read).**
  - `reg_re` pulses with `reg_addr` = pointer on the cycle after the `scl_fall` that ends the ACK slot.
  - `reg_rdata` is loaded into the shift register the next cycle; bit 7 is driven before the next `scl_rise`. The pointer increments after the load.
  - In RDAT_ACK, SDA is released and the master's bit is sampled. ACK (0) → next byte; NACK (1) → IDLE.
- **Pointer.** 16-bit, wraps 0xFFFF → 0x0000. It persists across transactions and resets to 0.
- **Transmit bits.** `sda_out_en` = ~bit, i.e. the line is driven low only for 0 bits and ACK.
- **Priority.** If `stop` or `start` coincides with an `scl` edge, `start`/`stop` wins.
- **Reset values.** All outputs 0; state IDLE; pointer 0x0000.

## Timing
- Input latency is 2 + FILT cycles. All strobes are single-cycle and never overlap.
- ACK drive: asserted the cycle after the 8th bit's `scl_fall`; released the cycle after the ACK slot's `scl_fall`.
- `reg_re` to data-on-SDA: 2 cycles. This requires an SCL low time ≥ 4 + FILT cycles.
- Partial byte then `stop`: no strobe fires and the pointer is unchanged.
- `rst` mid-transfer: SDA released on the next edge, state IDLE; the master sees an aborted frame.

## Structure
- Shared package `iic_pkg`: state enum and the address-byte-count constant (2). `DEV_ADDR` defaults per board part also go there.
- One sub-module, `iic_line_filter`: synchronizer, glitch filter and edge/START/STOP detect. The FSM, shift register and pointer stay in the top.

## Test plan
- **Write.** START, 0x56, 0x12, 0x34, 0xA5, STOP → four ACKs; one `reg_we` with addr 0x1234, data 0xA5.
- **Address mismatch.** START, 0x58 + three bytes → SDA never driven; no strobes; `busy` = 0.
- **Combined read.** Write pointer 0x0010, repeated START 0x57, read 2 bytes; bank[0x10] = 0x3C, bank[0x11] = 0xC3.
  - Expect bytes 0x3C, 0xC3; master NACK → IDLE; final pointer 0x0012.
- **Wrap-around.** Write pointer 0xFFFF, data 0x01, 0x02 → `reg_we` at 0xFFFF then 0x0000.
- **Aborts.**
  - STOP after 5 bits of a data byte → no `reg_we`; IDLE.
  - `rst` mid read → `sda_out_en` = 0 the next cycle.
- **Glitch rejection.** SCL glitch of FILT − 1 cycles during a data bit → ignored; the byte is received intact.
